// File: rtl/axi_sram_bridge_pkg.sv
// axi_sram_bridge_pkg: shared AXI constants, bridge FSM states and burst address stepping.
package axi_sram_bridge_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

   // Word address of the next beat; a WRAP window only exists for lens 1/3/7/15, else it steps like INCR.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [1:0] burst);
      logic        wrap;
      logic [31:0] mask;
      mask = {24'd0, len};
      wrap = burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      next_addr = burst == BURST_FIXED ? a :
                  wrap ? (a & ~mask) | ((a + 32'd1) & mask) : a + 32'd1;
   endfunction

endpackage

// File: rtl/axi_sram_rbuf.sv
// axi_sram_rbuf: 2-entry FIFO holding read beats (data + last) while the master stalls rready.
module axi_sram_rbuf (
   input  logic        aclk,
   input  logic        global_reset,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] din,
   input  logic        din_last,
   output logic [31:0] dout,
   output logic        dout_last,
   output logic        full,
   output logic        empty
);

   logic [32:0] mem [2];
   logic        wp, rp;
   logic [1:0]  cnt;

   assign full              = cnt == 2'd2;
   assign empty             = cnt == 2'd0;
   assign {dout_last, dout} = mem[rp];

   always_ff @(posedge aclk)
      if (push) mem[wp] <= {din_last, din};

   always_ff @(posedge aclk or posedge global_reset) begin
      if (global_reset) begin
         wp  <= 1'b0;
         rp  <= 1'b0;
         cnt <= 2'd0;
      end else begin
         wp  <= wp ^ push;
         rp  <= rp ^ pop;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/axi_sram_bridge.sv
// axi_sram_bridge: AXI4 slave serving one burst at a time from a single-port synchronous SRAM.
// Reads bypass the SRAM data straight to R when the beat buffer is empty, giving 2-cycle latency.
module axi_sram_bridge
   import axi_sram_bridge_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              aclk,
   input  logic              global_reset,
   input  logic [3:0]        arid,
   input  logic [31:0]       araddr,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [1:0]        arburst,
   input  logic              arvalid,
   output logic              arready,
   output logic [3:0]        rid,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   input  logic [3:0]        awid,
   input  logic [31:0]       awaddr,
   input  logic [7:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic [1:0]        awburst,
   input  logic              awvalid,
   output logic              awready,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [3:0]        bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   output logic              sram_en,
   output logic [3:0]        sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   state_t            state;
   logic              rd_first, pend, pend_last, werr;
   logic [3:0]        id_q;
   logic [7:0]        len_q;
   logic [1:0]        burst_q;
   logic [ADDR_W-1:0] addr_q;
   logic [8:0]        left;
   logic [31:0]       nxt, rb_data;
   logic              rb_last, rb_full, rb_empty, rb_push, rb_pop;
   logic              ar_hs, aw_hs, rd_issue, w_hs, last_beat, mism, r_done;
   logic              unused_ok;

   // On a tie only the arbitration winner sees ready, so exactly one channel handshakes.
   assign arready   = state == IDLE && !global_reset && !(arvalid && awvalid && !rd_first);
   assign awready   = state == IDLE && !global_reset && !(arvalid && awvalid && rd_first);
   assign ar_hs     = arvalid && arready;
   assign aw_hs     = awvalid && awready && !ar_hs;
   assign w_hs      = wvalid && wready;
   assign last_beat = left == 9'd1;
   assign mism      = wlast != last_beat;
   assign nxt       = next_addr(32'(addr_q), len_q, burst_q);

   // Issue only if the beat returning next cycle is sure to find a free slot.
   assign rd_issue = state == RD && left != 9'd0 && (rb_empty || (!rb_full && !pend));

   assign rvalid  = !rb_empty || pend;
   assign rdata   = rb_empty ? sram_rdata : rb_data;
   assign rlast   = rb_empty ? pend_last : rb_last;
   assign rid     = id_q;
   assign rresp   = RESP_OKAY;
   assign rb_pop  = rready && !rb_empty;
   assign rb_push = pend && !(rb_empty && rready);
   assign r_done  = rvalid && rready && rlast;
   assign bid     = id_q;

   assign sram_en    = rd_issue || w_hs;
   assign sram_we    = w_hs ? wstrb : 4'd0;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata;

   assign unused_ok = ^{arsize, awsize, araddr[31:ADDR_W+2], araddr[1:0],
                        awaddr[31:ADDR_W+2], awaddr[1:0], nxt[31:ADDR_W]};

   axi_sram_rbuf u_rbuf (
      .aclk         (aclk),
      .global_reset (global_reset),
      .push         (rb_push),
      .pop          (rb_pop),
      .din          (sram_rdata),
      .din_last     (pend_last),
      .dout         (rb_data),
      .dout_last    (rb_last),
      .full         (rb_full),
      .empty        (rb_empty)
   );

   always_ff @(posedge aclk or posedge global_reset) begin
      if (global_reset) begin
         state     <= IDLE;
         rd_first  <= 1'b1;
         pend      <= 1'b0;
         pend_last <= 1'b0;
         werr      <= 1'b0;
         id_q      <= 4'd0;
         len_q     <= 8'd0;
         burst_q   <= BURST_INCR;
         addr_q    <= '0;
         left      <= 9'd0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         bresp     <= RESP_OKAY;
      end else begin
         pend      <= rd_issue;
         pend_last <= rd_issue && last_beat;
         if (rd_issue || w_hs) begin
            addr_q <= nxt[ADDR_W-1:0];
            left   <= left - 9'd1;
         end
         case (state)
            IDLE:
               if (ar_hs) begin
                  id_q     <= arid;
                  len_q    <= arlen;
                  burst_q  <= arburst;
                  addr_q   <= araddr[ADDR_W+1:2];
                  left     <= {1'b0, arlen} + 9'd1;
                  rd_first <= 1'b0;
                  state    <= RD;
               end else if (aw_hs) begin
                  id_q     <= awid;
                  len_q    <= awlen;
                  burst_q  <= awburst;
                  addr_q   <= awaddr[ADDR_W+1:2];
                  left     <= {1'b0, awlen} + 9'd1;
                  rd_first <= 1'b1;
                  werr     <= 1'b0;
                  wready   <= 1'b1;
                  state    <= WR;
               end
            RD:
               if (r_done) state <= IDLE;
            WR:
               if (w_hs) begin
                  werr <= werr | mism;
                  if (last_beat) begin
                     wready <= 1'b0;
                     bvalid <= 1'b1;
                     bresp  <= (werr || mism) ? RESP_SLVERR : RESP_OKAY;
                     state  <= WRESP;
                  end
               end
            WRESP:
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// tb_axi_sram_bridge: scoreboard bench; SRAM accesses, R beats and B responses are queued at stimulus time.
module tb_axi_sram_bridge;
   import axi_sram_bridge_pkg::*;

   localparam int AW = 8;

   logic          aclk = 1'b0, global_reset = 1'b0;
   logic [3:0]    arid = '0, awid = '0, rid, bid;
   logic [31:0]   araddr = '0, awaddr = '0, rdata, wdata = '0, sram_wdata, sram_rdata = '0;
   logic [7:0]    arlen = '0, awlen = '0;
   logic [2:0]    arsize = '0, awsize = '0;
   logic [1:0]    arburst = '0, awburst = '0, rresp, bresp;
   logic          arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b1;
   logic          awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
   logic          bvalid, bready = 1'b1, sram_en;
   logic [3:0]    wstrb = '0, sram_we;
   logic [AW-1:0] sram_addr;

   typedef struct {logic [7:0] addr; logic [3:0] we; logic [31:0] data;} s_t;
   typedef struct {logic [31:0] data; logic last; logic [3:0] id;} r_t;
   typedef struct {logic [1:0] resp; logic [3:0] id;} b_t;

   s_t exp_s[$];
   r_t exp_r[$];
   b_t exp_b[$];
   s_t ms;
   r_t mr;
   b_t mb;

   logic [31:0] mem [0:(1<<AW)-1];
   logic [31:0] ref_mem [0:(1<<AW)-1];
   bit          mem_init = 1'b0;
   bit          mon_en = 1'b1;
   int          n_checks = 0, n_errors = 0, out_cnt = 0, max_out = 0;
   logic        other;

   axi_sram_bridge #(.ADDR_W(AW)) dut (
      .aclk(aclk), .global_reset(global_reset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 aclk = ~aclk;

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b ^ 8'hA5, 8'h3C, b, ~b};
   endfunction

   always @(posedge aclk) begin
      if (!mem_init) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (sram_en) begin
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         sram_rdata <= mem[sram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge aclk) begin
      if (mon_en && !global_reset) begin
         if (sram_en) begin
            if (exp_s.size() == 0) check("sram_extra", 32'(sram_en), 32'd0);
            else begin
               ms = exp_s.pop_front();
               check("sram_addr", 32'(sram_addr), 32'(ms.addr));
               check("sram_we", 32'(sram_we), 32'(ms.we));
               if (ms.we != 4'd0) check("sram_wdata", sram_wdata, ms.data);
            end
         end
         if (rvalid && rready) begin
            if (exp_r.size() == 0) check("r_extra", 32'(rvalid), 32'd0);
            else begin
               mr = exp_r.pop_front();
               check("rdata", rdata, mr.data);
               check("rlast", 32'(rlast), 32'(mr.last));
               check("rid", 32'(rid), 32'(mr.id));
               check("rresp", 32'(rresp), 32'd0);
            end
         end
         if (bvalid && bready) begin
            if (exp_b.size() == 0) check("b_extra", 32'(bvalid), 32'd0);
            else begin
               mb = exp_b.pop_front();
               check("bresp", 32'(bresp), 32'(mb.resp));
               check("bid", 32'(bid), 32'(mb.id));
            end
         end
         if (sram_en && sram_we == 4'd0) out_cnt++;
         if (rvalid && rready) out_cnt--;
         if (out_cnt > max_out) max_out = out_cnt;
      end
   end

   function automatic int nxt_word(input int a, input int len, input logic [1:0] burst);
      int sz;
      sz = len + 1;
      if (burst == 2'b00) return a;
      if (burst == 2'b10 && (sz == 2 || sz == 4 || sz == 8 || sz == 16))
         return (a / sz) * sz + (a + 1) % sz;
      return (a + 1) % (1 << AW);
   endfunction

   task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
      int a;
      a = int'(addr[AW+1:2]);
      for (int i = 0; i <= len; i++) begin
         exp_s.push_back('{8'(a), 4'h0, 32'h0});
         exp_r.push_back('{ref_mem[a], i == len, id});
         a = nxt_word(a, len, burst);
      end
   endtask

   task automatic push_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [3:0] strb,
                             input logic [31:0] base, input logic [1:0] resp);
      int a;
      logic [31:0] d;
      a = int'(addr[AW+1:2]);
      for (int i = 0; i <= len; i++) begin
         d = base + 32'(i);
         exp_s.push_back('{8'(a), strb, d});
         for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
         a = nxt_word(a, len, burst);
      end
      exp_b.push_back('{resp, id});
   endtask

   task automatic start_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
      arid = id; araddr = addr; arlen = 8'(len); arsize = 3'd2; arburst = burst; arvalid = 1'b1;
   endtask

   task automatic start_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
      awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd2; awburst = burst; awvalid = 1'b1;
   endtask

   task automatic wait_ar(output logic aw_seen);
      bit ok;
      ok = 1'b0;
      aw_seen = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge aclk);
         if (arready) begin
            ok = 1'b1;
            aw_seen = awready;
            break;
         end
      end
      check("ar_hs", 32'(ok), 32'd1);
      @(posedge aclk);
      #1 arvalid = 1'b0;
   endtask

   task automatic wait_aw(output logic ar_seen);
      bit ok;
      ok = 1'b0;
      ar_seen = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge aclk);
         if (awready) begin
            ok = 1'b1;
            ar_seen = arready && arvalid;
            break;
         end
      end
      check("aw_hs", 32'(ok), 32'd1);
      @(posedge aclk);
      #1 awvalid = 1'b0;
   endtask

   task automatic send_w(input int n, input logic [3:0] strb, input logic [31:0] base,
                         input int last_at);
      bit ok;
      for (int i = 0; i < n; i++) begin
         wvalid = 1'b1; wdata = base + 32'(i); wstrb = strb; wlast = (i == last_at);
         ok = 1'b0;
         for (int k = 0; k < 32; k++) begin
            @(negedge aclk);
            if (wready) begin
               ok = 1'b1;
               break;
            end
         end
         check("w_hs", 32'(ok), 32'd1);
         @(posedge aclk);
         #1;
      end
      wvalid = 1'b0;
      wlast = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge aclk);
         if (exp_s.size() == 0 && exp_r.size() == 0 && exp_b.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain", 32'(ok), 32'd1);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;
      bit ok;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
      #2 global_reset = 1'b1;
      repeat (3) @(negedge aclk);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_sram_en", 32'(sram_en), 32'd0);
      @(posedge aclk);
      #1 global_reset = 1'b0;
      @(negedge aclk);
      check("idle_arready", 32'(arready), 32'd1);
      check("idle_awready", 32'(awready), 32'd1);
      @(posedge aclk);
      #1;

      // Arbitration from reset: read, write, then read again.
      start_ar(4'd1, 32'h20, 1, BURST_INCR);
      start_aw(4'd2, 32'h80, 0, BURST_INCR);
      push_read(4'd1, 32'h20, 1, BURST_INCR);
      push_write(4'd2, 32'h80, 0, BURST_INCR, 4'hF, 32'h0BAD_0001, RESP_OKAY);
      wait_ar(other);
      check("arb1_aw_ready", 32'(other), 32'd0);
      wait_aw(other);
      send_w(1, 4'hF, 32'h0BAD_0001, 0);
      drain();
      start_ar(4'd1, 32'h24, 0, BURST_INCR);
      start_aw(4'd2, 32'h84, 0, BURST_INCR);
      push_read(4'd1, 32'h24, 0, BURST_INCR);
      push_write(4'd2, 32'h84, 0, BURST_INCR, 4'hF, 32'h0BAD_0002, RESP_OKAY);
      wait_ar(other);
      check("arb2_aw_ready", 32'(other), 32'd0);
      wait_aw(other);
      send_w(1, 4'hF, 32'h0BAD_0002, 0);
      drain();

      // INCR read with rready high: latency and throughput.
      start_ar(4'd3, 32'h100, 3, BURST_INCR);
      push_read(4'd3, 32'h100, 3, BURST_INCR);
      wait_ar(other);
      @(negedge aclk);
      check("rd_lat_en", 32'(sram_en), 32'd1);
      check("rd_lat_rv0", 32'(rvalid), 32'd0);
      @(negedge aclk);
      check("rd_lat_rv1", 32'(rvalid), 32'd1);
      @(posedge aclk);
      #1;
      drain();

      // Same read with rready toggling every cycle.
      start_ar(4'd3, 32'h100, 3, BURST_INCR);
      push_read(4'd3, 32'h100, 3, BURST_INCR);
      wait_ar(other);
      for (int n = 0; n < 60 && exp_r.size() != 0; n++) begin
         rready = ~rready;
         @(posedge aclk);
         #1;
      end
      rready = 1'b1;
      check("toggle_done", 32'(exp_r.size()), 32'd0);
      drain();

      // Long stall with the buffer full.
      start_ar(4'd4, 32'h200, 7, BURST_INCR);
      push_read(4'd4, 32'h200, 7, BURST_INCR);
      rready = 1'b0;
      wait_ar(other);
      repeat (6) @(posedge aclk);
      #1 rready = 1'b1;
      drain();
      check("max_outstanding_ok", 32'(max_out <= 2), 32'd1);

      // WRAP write with partial strobes, then read the window back.
      start_aw(4'd5, 32'h8, 7, BURST_WRAP);
      push_write(4'd5, 32'h8, 7, BURST_WRAP, 4'b0011, 32'h1111_0000, RESP_OKAY);
      wait_aw(other);
      check("wready_lat", 32'(wready), 32'd1);
      send_w(8, 4'b0011, 32'h1111_0000, 7);
      @(negedge aclk);
      check("bvalid_lat", 32'(bvalid), 32'd1);
      @(posedge aclk);
      #1;
      drain();
      start_ar(4'd6, 32'h0, 7, BURST_INCR);
      push_read(4'd6, 32'h0, 7, BURST_INCR);
      wait_ar(other);
      drain();

      // Early wlast: burst still runs to awlen+1 beats, answered with SLVERR.
      start_aw(4'd7, 32'h40, 1, BURST_INCR);
      push_write(4'd7, 32'h40, 1, BURST_INCR, 4'hF, 32'hCAFE_0000, RESP_SLVERR);
      wait_aw(other);
      send_w(2, 4'hF, 32'hCAFE_0000, 0);
      drain();

      // FIXED, WRAP with non-window len, and ignored upper address bits.
      start_ar(4'd8, 32'h30, 2, BURST_FIXED);
      push_read(4'd8, 32'h30, 2, BURST_FIXED);
      wait_ar(other);
      drain();
      start_ar(4'd9, 32'h14, 2, BURST_WRAP);
      push_read(4'd9, 32'h14, 2, BURST_WRAP);
      wait_ar(other);
      drain();
      start_ar(4'hA, 32'hFFFF_0104, 0, BURST_INCR);
      arsize = 3'd5;
      push_read(4'hA, 32'hFFFF_0104, 0, BURST_INCR);
      wait_ar(other);
      drain();

      // Reset during beat 2 of a len=7 read.
      mon_en = 1'b0;
      start_ar(4'hB, 32'h0, 7, BURST_INCR);
      wait_ar(other);
      beats = 0;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge aclk);
         if (beats == 1 && rvalid) begin
            ok = 1'b1;
            break;
         end
         if (rvalid && rready) beats++;
      end
      check("beat2_seen", 32'(ok), 32'd1);
      #1 global_reset = 1'b1;
      #1;
      check("rst_mid_rvalid", 32'(rvalid), 32'd0);
      check("rst_mid_sram_en", 32'(sram_en), 32'd0);
      check("rst_mid_arready", 32'(arready), 32'd0);
      repeat (2) begin
         @(negedge aclk);
         check("rst_hold_sram_en", 32'(sram_en), 32'd0);
      end
      @(posedge aclk);
      #1 global_reset = 1'b0;
      @(negedge aclk);
      check("post_rst_arready", 32'(arready), 32'd1);
      check("post_rst_awready", 32'(awready), 32'd1);
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
      repeat (3) begin
         @(negedge aclk);
         check("post_rst_sram_en", 32'(sram_en), 32'd0);
      end
      mon_en = 1'b1;
      @(posedge aclk);
      #1;
      start_ar(4'hC, 32'h10, 1, BURST_INCR);
      push_read(4'hC, 32'h10, 1, BURST_INCR);
      wait_ar(other);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
